multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle MIPS control unit: the initiator side of the ALU control interface.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Drives ALU control code and operand selects, and consumes the ALU zero flag for branches.
- Sits between the instruction register/memory interface and the datapath muxes, register file and PC.

Parameters:
- RESET_PC_SOURCE, 2'b00, pc_source value held during reset and in FETCH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- instr  input  32  current instruction register contents
- mem_ready  input  1  memory access completes this cycle
- alu_zero  input  1  ALU result==0 flag
- alu_control  output  4  ALU operation code (libAlu ALU_* codes)
- alu_src_a  output  2  0=PC, 1=regA, 2=shamt zero-extended
- alu_src_b  output  3  0=regB, 1=const 4, 2=sext imm, 3=sext imm<<2, 4=zext imm
- iord  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  latch instruction register
- pc_write  output  1  PC update enable (includes resolved branch)
- pc_source  output  2  0=ALU result, 1=ALUOut, 2=jump target
- reg_write  output  1  register file write enable
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- illegal  output  1  unsupported opcode/funct seen (feature-dependent)

Behaviour:
- Reset: synchronous, active-high. State <= FETCH.
- While reset is high, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write) are 0, alu_control=ALU_ZERO, all selects 0, pc_source=RESET_PC_SOURCE, and illegal=0.
- Outputs are decoded from the registered state plus instr (Moore-style); no output depends on mem_ready except the completion strobes listed below.
- Reset asserted mid-instruction: the instruction is abandoned and no write strobes fire in the reset cycle.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_control=ALU_ADD, pc_source=0.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1, which also moves the state to DECODE.
  - Otherwise the state holds in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, ALU_ADD (branch target precompute). Next state by opcode:
  - R-type (0x00) -> EXEC_R
  - lw (0x23) / sw (0x2B) -> MEM_ADDR
  - beq (0x04) / bne (0x05) -> BRANCH
  - j (0x02) -> JUMP
  - addi/addiu/slti/andi/ori/xori/lui -> EXEC_I
  - anything else -> ILLEGAL handling
- EXEC_R: alu_src_b=0. ALU code from funct:
  - 20/21 -> ADD; 22/23 -> SUB; 24 -> AND; 25 -> OR; 26 -> XOR; 27 -> NOR; 2A -> SLT
  - 00 -> SLL, 02 -> SRL, 03 -> SRA, each with alu_src_a=2; all other R-type funct codes use alu_src_a=1
  - Unknown funct -> ILLEGAL handling
  - Next state: R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1.
  - addi/addiu -> ADD with src_b=2; slti -> SLT with src_b=2
  - andi/ori/xori -> AND/OR/XOR with src_b=4
  - lui -> LUI with src_b=4
  - Next state: I_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ALU_ADD. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: iord=1, mem_read=1; holds until mem_ready, then -> MEM_WB (reg_write=1, reg_dst=0, mem_to_reg=1) -> FETCH.
- MEM_WR: iord=1, mem_write=1; holds until mem_ready, then -> FETCH.
  - mem_write stays asserted for every cycle in MEM_WR.
- BRANCH: alu_src_a=1, alu_src_b=0, ALU_SUB, pc_source=1.
  - pc_write = beq ? alu_zero : ~alu_zero.
  - -> FETCH.
- JUMP: pc_source=2, pc_write=1 -> FETCH.
- Zero-wait latency in cycles: R/I-type 4, lw 5, sw 4, branch 3, jump 3. Each wait cycle on mem_ready adds 1.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode/funct enters TRAP state. TRAP has no strobes and no exit except reset; illegal=1 while in TRAP.
- Undefined: an unsupported opcode/funct is treated as a NOP. DECODE/EXEC_R returns to FETCH with no write strobes; illegal is tied 0.

Decomposition:
- Package libControl holds:
  - state enum (FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP)
  - opcode and funct localparams
  - ALU_SRC_A_* and ALU_SRC_B_* select constants
- ALU codes are imported from libAlu.
- Sub-module alu_op_decoder (combinational): maps opcode, funct and state class to alu_control, alu_src_a and alu_src_b, plus an unsupported flag.

Test Plan:
- add $3,$1,$2 (0x00221820), mem_ready=1 -> over 4 cycles:
  - alu_control: ADD, ADD, ADD
  - R_WB: reg_write=1, reg_dst=1
  - back in FETCH at cycle 5
- lw (0x8C220004) with mem_ready low 2 cycles in MEM_RD -> mem_read held 3 cycles, iord=1; mem_to_reg=1 with reg_write=1 exactly once.
- beq (0x10220003):
  - alu_zero=1 -> BRANCH cycle: pc_write=1, pc_source=1
  - alu_zero=0 -> pc_write=0
  - bne (0x14220003) inverts both results.
- sll $2,$1,4 (0x00011100) -> EXEC_R: alu_control=SLL, alu_src_a=2; ori (0x34220FF0) -> alu_control=OR, alu_src_b=4.
- Reset asserted in MEM_WR -> next cycle state FETCH, mem_write=0, no reg_write.
- Opcode 0x3F:
  - with MULTICYCLE_ILLEGAL_TRAP_EN, illegal=1 and sticky, FSM parked until reset
  - without it, returns to FETCH after DECODE with zero strobes

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// ALU operation codes (libAlu) and multicycle control definitions (libControl):
// FSM states, decoder state classes, MIPS opcode/funct values and operand selects.
package libAlu;
   localparam logic [3:0] ALU_ZERO = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_NOR  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;
endpackage

package libControl;
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      R_WB     = 4'd3,
      EXEC_I   = 4'd4,
      I_WB     = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      MEM_WB   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      TRAP     = 4'd12
   } state_e;

   // Coarse view of the FSM state: only these states drive the ALU.
   typedef enum logic [2:0] {
      CLS_FETCH    = 3'd0,
      CLS_DECODE   = 3'd1,
      CLS_EXEC_R   = 3'd2,
      CLS_EXEC_I   = 3'd3,
      CLS_MEM_ADDR = 3'd4,
      CLS_BRANCH   = 3'd5,
      CLS_OTHER    = 3'd6
   } alu_class_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [1:0] ALU_SRC_A_PC    = 2'd0;
   localparam logic [1:0] ALU_SRC_A_REGA  = 2'd1;
   localparam logic [1:0] ALU_SRC_A_SHAMT = 2'd2;

   localparam logic [2:0] ALU_SRC_B_REGB     = 3'd0;
   localparam logic [2:0] ALU_SRC_B_FOUR     = 3'd1;
   localparam logic [2:0] ALU_SRC_B_SEXT     = 3'd2;
   localparam logic [2:0] ALU_SRC_B_SEXT_SH2 = 3'd3;
   localparam logic [2:0] ALU_SRC_B_ZEXT     = 3'd4;

   function automatic logic opcode_supported(input logic [5:0] opcode);
      logic ok;
      case (opcode)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit side bus: instruction/memory status in, datapath controls out.
interface multicycle_control_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic [3:0]  alu_control;
   logic [1:0]  alu_src_a;
   logic [2:0]  alu_src_b;
   logic        iord;
   logic        mem_read;
   logic        mem_write;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_source;
   logic        reg_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        illegal;

   modport master (
      input  instr, mem_ready, alu_zero,
      output alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
             ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg, illegal
   );

   modport slave (
      output instr, mem_ready, alu_zero,
      input  alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
             ir_write, pc_write, pc_source, reg_write, reg_dst, mem_to_reg, illegal
   );
endinterface

// File: rtl/multicycle_control_alu_op_decoder.sv
// alu_op_decoder: combinational map of (state class, opcode, funct) to ALU code,
// operand selects and an "unsupported in this class" flag.
module alu_op_decoder
   import libAlu::*;
   import libControl::*;
(
   input  alu_class_e  class_i,
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   output logic [3:0]  alu_control_o,
   output logic [1:0]  alu_src_a_o,
   output logic [2:0]  alu_src_b_o,
   output logic        unsupported_o
);

   always_comb begin
      alu_control_o = ALU_ZERO;
      alu_src_a_o   = ALU_SRC_A_PC;
      alu_src_b_o   = ALU_SRC_B_REGB;
      unsupported_o = 1'b0;
      case (class_i)
         CLS_FETCH: begin
            alu_control_o = ALU_ADD;
            alu_src_b_o   = ALU_SRC_B_FOUR;
         end
         CLS_DECODE: begin
            alu_control_o = ALU_ADD;
            alu_src_b_o   = ALU_SRC_B_SEXT_SH2;
            unsupported_o = ~opcode_supported(opcode_i);
         end
         CLS_EXEC_R: begin
            alu_src_a_o = ALU_SRC_A_REGA;
            case (funct_i)
               FN_ADD, FN_ADDU: alu_control_o = ALU_ADD;
               FN_SUB, FN_SUBU: alu_control_o = ALU_SUB;
               FN_AND:          alu_control_o = ALU_AND;
               FN_OR:           alu_control_o = ALU_OR;
               FN_XOR:          alu_control_o = ALU_XOR;
               FN_NOR:          alu_control_o = ALU_NOR;
               FN_SLT:          alu_control_o = ALU_SLT;
               FN_SLL: begin
                  alu_control_o = ALU_SLL;
                  alu_src_a_o   = ALU_SRC_A_SHAMT;
               end
               FN_SRL: begin
                  alu_control_o = ALU_SRL;
                  alu_src_a_o   = ALU_SRC_A_SHAMT;
               end
               FN_SRA: begin
                  alu_control_o = ALU_SRA;
                  alu_src_a_o   = ALU_SRC_A_SHAMT;
               end
               default:         unsupported_o = 1'b1;
            endcase
         end
         CLS_EXEC_I: begin
            alu_src_a_o = ALU_SRC_A_REGA;
            case (opcode_i)
               OP_ADDI, OP_ADDIU: begin
                  alu_control_o = ALU_ADD;
                  alu_src_b_o   = ALU_SRC_B_SEXT;
               end
               OP_SLTI: begin
                  alu_control_o = ALU_SLT;
                  alu_src_b_o   = ALU_SRC_B_SEXT;
               end
               OP_ANDI: begin
                  alu_control_o = ALU_AND;
                  alu_src_b_o   = ALU_SRC_B_ZEXT;
               end
               OP_ORI: begin
                  alu_control_o = ALU_OR;
                  alu_src_b_o   = ALU_SRC_B_ZEXT;
               end
               OP_XORI: begin
                  alu_control_o = ALU_XOR;
                  alu_src_b_o   = ALU_SRC_B_ZEXT;
               end
               OP_LUI: begin
                  alu_control_o = ALU_LUI;
                  alu_src_b_o   = ALU_SRC_B_ZEXT;
               end
               default: alu_control_o = ALU_ZERO;
            endcase
         end
         CLS_MEM_ADDR: begin
            alu_control_o = ALU_ADD;
            alu_src_a_o   = ALU_SRC_A_REGA;
            alu_src_b_o   = ALU_SRC_B_SEXT;
         end
         CLS_BRANCH: begin
            alu_control_o = ALU_SUB;
            alu_src_a_o   = ALU_SRC_A_REGA;
         end
         default: alu_control_o = ALU_ZERO;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Optional macro MULTICYCLE_ILLEGAL_TRAP_EN parks the
// FSM in TRAP on unsupported opcode/funct; otherwise such instructions act as NOPs.
module multicycle_control
   import libAlu::*;
   import libControl::*;
#(
   parameter logic [1:0] RESET_PC_SOURCE = 2'b00
)(
   input  logic                  clk,
   input  logic                  reset,
   multicycle_control_if.master  bus
);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   localparam state_e ILL_NEXT = TRAP;
`else
   localparam state_e ILL_NEXT = FETCH;
`endif

   state_e     state_q, state_d;
   alu_class_e alu_class_s;
   logic [5:0] opcode_s, funct_s;
   logic [3:0] dec_alu_control_s;
   logic [1:0] dec_alu_src_a_s;
   logic [2:0] dec_alu_src_b_s;
   logic       dec_unsupported_s;
   logic       unused_instr_s;

   logic [3:0] alu_control_s;
   logic [1:0] alu_src_a_s, pc_source_s;
   logic [2:0] alu_src_b_s;
   logic       iord_s, mem_read_s, mem_write_s, ir_write_s, pc_write_s;
   logic       reg_write_s, reg_dst_s, mem_to_reg_s, illegal_s;

   assign opcode_s       = bus.instr[31:26];
   assign funct_s        = bus.instr[5:0];
   assign unused_instr_s = ^bus.instr[25:6];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Collapse the state into the class the ALU decoder cares about.
   always_comb begin
      alu_class_s = CLS_OTHER;
      case (state_q)
         FETCH:    alu_class_s = CLS_FETCH;
         DECODE:   alu_class_s = CLS_DECODE;
         EXEC_R:   alu_class_s = CLS_EXEC_R;
         EXEC_I:   alu_class_s = CLS_EXEC_I;
         MEM_ADDR: alu_class_s = CLS_MEM_ADDR;
         BRANCH:   alu_class_s = CLS_BRANCH;
         default:  alu_class_s = CLS_OTHER;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .class_i       (alu_class_s),
      .opcode_i      (opcode_s),
      .funct_i       (funct_s),
      .alu_control_o (dec_alu_control_s),
      .alu_src_a_o   (dec_alu_src_a_s),
      .alu_src_b_o   (dec_alu_src_b_s),
      .unsupported_o (dec_unsupported_s)
   );

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            if (dec_unsupported_s) begin
               state_d = ILL_NEXT;
            end else begin
               case (opcode_s)
                  OP_RTYPE:      state_d = EXEC_R;
                  OP_LW, OP_SW:  state_d = MEM_ADDR;
                  OP_BEQ, OP_BNE: state_d = BRANCH;
                  OP_J:          state_d = JUMP;
                  default:       state_d = EXEC_I;
               endcase
            end
         end
         EXEC_R:   state_d = dec_unsupported_s ? ILL_NEXT : R_WB;
         EXEC_I:   state_d = I_WB;
         MEM_ADDR: state_d = (opcode_s == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   state_d = bus.mem_ready ? MEM_WB : MEM_RD;
         MEM_WR:   state_d = bus.mem_ready ? FETCH : MEM_WR;
         R_WB, I_WB, MEM_WB, BRANCH, JUMP: state_d = FETCH;
         TRAP:     state_d = TRAP;
         default:  state_d = FETCH;
      endcase
   end

   // Output decode; reset forces the quiescent pattern regardless of state.
   always_comb begin
      alu_control_s = dec_alu_control_s;
      alu_src_a_s   = dec_alu_src_a_s;
      alu_src_b_s   = dec_alu_src_b_s;
      pc_source_s   = 2'b00;
      iord_s        = 1'b0;
      mem_read_s    = 1'b0;
      mem_write_s   = 1'b0;
      ir_write_s    = 1'b0;
      pc_write_s    = 1'b0;
      reg_write_s   = 1'b0;
      reg_dst_s     = 1'b0;
      mem_to_reg_s  = 1'b0;
      if (reset) begin
         alu_control_s = ALU_ZERO;
         alu_src_a_s   = ALU_SRC_A_PC;
         alu_src_b_s   = ALU_SRC_B_REGB;
         pc_source_s   = RESET_PC_SOURCE;
      end else begin
         case (state_q)
            FETCH: begin
               mem_read_s  = 1'b1;
               ir_write_s  = bus.mem_ready;
               pc_write_s  = bus.mem_ready;
               pc_source_s = RESET_PC_SOURCE;
            end
            R_WB: begin
               reg_write_s = 1'b1;
               reg_dst_s   = 1'b1;
            end
            I_WB:   reg_write_s = 1'b1;
            MEM_RD: begin
               iord_s     = 1'b1;
               mem_read_s = 1'b1;
            end
            MEM_WB: begin
               reg_write_s  = 1'b1;
               mem_to_reg_s = 1'b1;
            end
            MEM_WR: begin
               iord_s      = 1'b1;
               mem_write_s = 1'b1;
            end
            BRANCH: begin
               pc_source_s = 2'd1;
               pc_write_s  = (opcode_s == OP_BEQ) ? bus.alu_zero : ~bus.alu_zero;
            end
            JUMP: begin
               pc_source_s = 2'd2;
               pc_write_s  = 1'b1;
            end
            default: pc_source_s = 2'b00;
         endcase
      end
   end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
   assign illegal_s = ~reset & (state_q == TRAP);
`else
   assign illegal_s = 1'b0;
`endif

   assign bus.alu_control = alu_control_s;
   assign bus.alu_src_a   = alu_src_a_s;
   assign bus.alu_src_b   = alu_src_b_s;
   assign bus.iord        = iord_s;
   assign bus.mem_read    = mem_read_s;
   assign bus.mem_write   = mem_write_s;
   assign bus.ir_write    = ir_write_s;
   assign bus.pc_write    = pc_write_s;
   assign bus.pc_source   = pc_source_s;
   assign bus.reg_write   = reg_write_s;
   assign bus.reg_dst     = reg_dst_s;
   assign bus.mem_to_reg  = mem_to_reg_s;
   assign bus.illegal     = illegal_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model expands each
// instruction into its phase list; per-cycle expected outputs are queued and checked.
module tb_multicycle_control;
   import libAlu::*;

   localparam logic [1:0] RPS = 2'b00;

   localparam int P_FETCH = 0;
   localparam int P_DEC   = 1;
   localparam int P_EXR   = 2;
   localparam int P_RWB   = 3;
   localparam int P_EXI   = 4;
   localparam int P_IWB   = 5;
   localparam int P_MA    = 6;
   localparam int P_MRD   = 7;
   localparam int P_MWB   = 8;
   localparam int P_MWR   = 9;
   localparam int P_BR    = 10;
   localparam int P_J     = 11;
   localparam int P_TRAP  = 12;
   localparam int P_RST   = 13;

   typedef struct packed {
      logic [3:0] alu_control;
      logic [1:0] alu_src_a;
      logic [2:0] alu_src_b;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } outs_t;

   logic clk;
   logic reset;
   multicycle_control_if bus_if ();

   multicycle_control #(.RESET_PC_SOURCE(RPS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   outs_t exp_q[$];
   int    ph_q[$];
   int    plan[$];
   int    checks   = 0;
   int    failures = 0;
   int    n_pushed = 0;
   int    n_popped = 0;

   logic [5:0] op_pool [18] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                                6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h3F, 6'h01, 6'h11};
   logic [5:0] fn_pool [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};

   function automatic string pname(int p);
      case (p)
         P_FETCH: return "fetch";
         P_DEC:   return "decode";
         P_EXR:   return "exec_r";
         P_RWB:   return "r_wb";
         P_EXI:   return "exec_i";
         P_IWB:   return "i_wb";
         P_MA:    return "mem_addr";
         P_MRD:   return "mem_rd";
         P_MWB:   return "mem_wb";
         P_MWR:   return "mem_wr";
         P_BR:    return "branch";
         P_J:     return "jump";
         P_TRAP:  return "trap";
         default: return "reset";
      endcase
   endfunction

   function automatic bit op_known(logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                        6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   endfunction

   function automatic bit fn_known(logic [5:0] fn);
      return fn inside {6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                        6'h25, 6'h26, 6'h27, 6'h2A};
   endfunction

   function automatic void illegal_tail();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      for (int i = 0; i < 5; i++) plan.push_back(P_TRAP);
`endif
   endfunction

   // Instruction -> ordered list of phases it walks through.
   function automatic void build_plan(logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      plan = {};
      plan.push_back(P_FETCH);
      plan.push_back(P_DEC);
      if (!op_known(op)) illegal_tail();
      else if (op == 6'h00) begin
         plan.push_back(P_EXR);
         if (fn_known(ins[5:0])) plan.push_back(P_RWB);
         else illegal_tail();
      end
      else if (op == 6'h23) begin
         plan.push_back(P_MA); plan.push_back(P_MRD); plan.push_back(P_MWB);
      end
      else if (op == 6'h2B) begin
         plan.push_back(P_MA); plan.push_back(P_MWR);
      end
      else if (op == 6'h04 || op == 6'h05) plan.push_back(P_BR);
      else if (op == 6'h02) plan.push_back(P_J);
      else begin
         plan.push_back(P_EXI); plan.push_back(P_IWB);
      end
   endfunction

   function automatic outs_t exp_out(int p, logic [31:0] ins, logic mr, logic z);
      outs_t o;
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      o = '0;
      o.alu_control = ALU_ZERO;
      case (p)
         P_RST: o.pc_source = RPS;
         P_FETCH: begin
            o.mem_read = 1'b1; o.alu_src_b = 3'd1; o.alu_control = ALU_ADD;
            o.pc_source = RPS; o.ir_write = mr; o.pc_write = mr;
         end
         P_DEC: begin o.alu_src_b = 3'd3; o.alu_control = ALU_ADD; end
         P_EXR: begin
            o.alu_src_a = 2'd1;
            case (fn)
               6'h20, 6'h21: o.alu_control = ALU_ADD;
               6'h22, 6'h23: o.alu_control = ALU_SUB;
               6'h24: o.alu_control = ALU_AND;
               6'h25: o.alu_control = ALU_OR;
               6'h26: o.alu_control = ALU_XOR;
               6'h27: o.alu_control = ALU_NOR;
               6'h2A: o.alu_control = ALU_SLT;
               6'h00: begin o.alu_control = ALU_SLL; o.alu_src_a = 2'd2; end
               6'h02: begin o.alu_control = ALU_SRL; o.alu_src_a = 2'd2; end
               6'h03: begin o.alu_control = ALU_SRA; o.alu_src_a = 2'd2; end
               default: o.alu_control = ALU_ZERO;
            endcase
         end
         P_RWB: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
         P_EXI: begin
            o.alu_src_a = 2'd1;
            case (op)
               6'h08, 6'h09: begin o.alu_control = ALU_ADD; o.alu_src_b = 3'd2; end
               6'h0A: begin o.alu_control = ALU_SLT; o.alu_src_b = 3'd2; end
               6'h0C: begin o.alu_control = ALU_AND; o.alu_src_b = 3'd4; end
               6'h0D: begin o.alu_control = ALU_OR;  o.alu_src_b = 3'd4; end
               6'h0E: begin o.alu_control = ALU_XOR; o.alu_src_b = 3'd4; end
               default: begin o.alu_control = ALU_LUI; o.alu_src_b = 3'd4; end
            endcase
         end
         P_IWB: o.reg_write = 1'b1;
         P_MA: begin o.alu_src_a = 2'd1; o.alu_src_b = 3'd2; o.alu_control = ALU_ADD; end
         P_MRD: begin o.iord = 1'b1; o.mem_read = 1'b1; end
         P_MWB: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
         P_MWR: begin o.iord = 1'b1; o.mem_write = 1'b1; end
         P_BR: begin
            o.alu_src_a = 2'd1; o.alu_control = ALU_SUB; o.pc_source = 2'd1;
            o.pc_write = (op == 6'h04) ? z : ~z;
         end
         P_J: begin o.pc_source = 2'd2; o.pc_write = 1'b1; end
         default: o.illegal = 1'b1;
      endcase
      return o;
   endfunction

   task automatic do_cycle(int p, logic mr, logic z);
      reset = 1'b0;
      bus_if.mem_ready = mr;
      bus_if.alu_zero  = z;
      exp_q.push_back(exp_out(p, bus_if.instr, mr, z));
      ph_q.push_back(p);
      n_pushed++;
      @(posedge clk); #1;
   endtask

   task automatic do_reset_cycle();
      reset = 1'b1;
      bus_if.mem_ready = 1'b1;
      bus_if.alu_zero  = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_out(P_RST, bus_if.instr, 1'b1, 1'b0));
      ph_q.push_back(P_RST);
      n_pushed++;
      @(posedge clk); #1;
   endtask

   function automatic logic pick_z(int zf);
      if (zf < 0) return 1'($urandom_range(0, 1));
      return (zf != 0);
   endfunction

   task automatic run_instr(logic [31:0] ins, int fixed_wait, int zf);
      int p, nw;
      bus_if.instr = ins;
      build_plan(ins);
      p = P_FETCH;
      foreach (plan[k]) begin
         p = plan[k];
         if (p == P_FETCH || p == P_MRD || p == P_MWR) begin
            if (fixed_wait >= 0 && p != P_FETCH) nw = fixed_wait;
            else nw = int'($urandom_range(0, 2));
            repeat (nw) do_cycle(p, 1'b0, pick_z(zf));
            do_cycle(p, 1'b1, pick_z(zf));
         end else begin
            do_cycle(p, 1'($urandom_range(0, 1)), pick_z(zf));
         end
      end
      if (p == P_TRAP) do_reset_cycle();
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      outs_t a, e;
      int p;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         p = ph_q.pop_front();
         n_popped++;
         a.alu_control = bus_if.alu_control;
         a.alu_src_a   = bus_if.alu_src_a;
         a.alu_src_b   = bus_if.alu_src_b;
         a.iord        = bus_if.iord;
         a.mem_read    = bus_if.mem_read;
         a.mem_write   = bus_if.mem_write;
         a.ir_write    = bus_if.ir_write;
         a.pc_write    = bus_if.pc_write;
         a.pc_source   = bus_if.pc_source;
         a.reg_write   = bus_if.reg_write;
         a.reg_dst     = bus_if.reg_dst;
         a.mem_to_reg  = bus_if.mem_to_reg;
         a.illegal     = bus_if.illegal;
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s instr=%h actual=%h required=%h", pname(p), bus_if.instr, a, e);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      reset = 1'b1;
      bus_if.instr     = 32'h0000_0000;
      bus_if.mem_ready = 1'b0;
      bus_if.alu_zero  = 1'b0;
      @(posedge clk); #1;
      do_reset_cycle();
      do_reset_cycle();

      run_instr(32'h0022_1820, 0, -1);   // add
      run_instr(32'h8C22_0004, 2, -1);   // lw, two wait cycles in MEM_RD
      run_instr(32'h1022_0003, -1, 1);   // beq taken
      run_instr(32'h1022_0003, -1, 0);   // beq not taken
      run_instr(32'h1422_0003, -1, 1);   // bne
      run_instr(32'h1422_0003, -1, 0);
      run_instr(32'h0001_1100, -1, -1);  // sll
      run_instr(32'h3422_0FF0, -1, -1);  // ori
      run_instr(32'h0800_0010, -1, -1);  // j
      run_instr(32'hAC22_0008, 1, -1);   // sw
      run_instr(32'h3C01_1234, -1, -1);  // lui

      // Reset lands while a store is waiting on memory.
      bus_if.instr = 32'hAC22_0008;
      do_cycle(P_FETCH, 1'b1, 1'b0);
      do_cycle(P_DEC, 1'b0, 1'b0);
      do_cycle(P_MA, 1'b1, 1'b0);
      do_cycle(P_MWR, 1'b0, 1'b0);
      do_cycle(P_MWR, 1'b0, 1'b1);
      do_reset_cycle();
      run_instr(32'h0022_1820, -1, -1);

      run_instr(32'hFC00_0000, -1, -1);  // opcode 0x3F
      run_instr(32'h0000_0008, -1, -1);  // unsupported funct
      run_instr(32'h0022_1822, -1, -1);  // sub

      for (int n = 0; n < 80; n++) begin
         ins = $urandom;
         ins[31:26] = op_pool[$urandom_range(0, 17)];
         if (ins[31:26] == 6'h00) ins[5:0] = fn_pool[$urandom_range(0, 13)];
         run_instr(ins, -1, -1);
      end

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0 || n_popped != n_pushed) begin
         failures++;
         $display("FAIL drain actual_popped=%0d required=%0d", n_popped, n_pushed);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
